// File: rtl/keccak_theta_parity_acc_if.sv
// Plane-in / parity-out bus for the Keccak theta column-parity accumulator.
// The master is the side that supplies planes and consumes parity results.
interface keccak_theta_parity_acc_if #(
   parameter int LaneW = 64
);
   localparam int WordW = 4 * LaneW;

   logic             in_valid_i;
   logic             in_ready_o;
   logic [WordW-1:0] plane_a_i;
   logic [WordW-1:0] plane_b_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [WordW-1:0] parity_a_o;
   logic [WordW-1:0] parity_b_o;
   logic [2:0]       plane_cnt_o;

   modport master (
      output in_valid_i, plane_a_i, plane_b_i, out_ready_i,
      input  in_ready_o, out_valid_o, parity_a_o, parity_b_o, plane_cnt_o
   );

   modport slave (
      input  in_valid_i, plane_a_i, plane_b_i, out_ready_i,
      output in_ready_o, out_valid_o, parity_a_o, parity_b_o, plane_cnt_o
   );
endinterface

// File: rtl/keccak_theta_parity_acc.sv
// Keccak theta column-parity accumulator: XOR-folds five 320-bit planes into
// C[x] and hands the result to the plane unit in its two-word packing.
module keccak_theta_parity_acc #(
   parameter int NumPlanes = 5,
   parameter int LaneW     = 64
) (
   input logic                      clk_i,
   input logic                      rst_i,
   input logic                      clear_i,
   keccak_theta_parity_acc_if.slave bus
);
   localparam int WordW = 4 * LaneW;

   typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_FULL} state_t;

   state_t             state_q;
   logic [2:0]         cnt_q;
   logic [WordW-1:0]   acc_a_q;
   logic [LaneW-1:0]   acc_b_q;

   logic [WordW-1:0]   xor_a;
   logic [LaneW-1:0]   xor_b;
   logic               in_ready;
   logic               accept;
   logic               out_fire;

   // Upper bits of word B carry no lane and are deliberately ignored.
   logic unused_plane_b_hi;
   assign unused_plane_b_hi = ^bus.plane_b_i[WordW-1:LaneW];

   // Per-lane XOR of the running parity with the incoming plane; lanes never mix.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign xor_a[gi*LaneW +: LaneW] = acc_a_q[gi*LaneW +: LaneW] ^ bus.plane_a_i[gi*LaneW +: LaneW];
      end
   endgenerate
   assign xor_b = acc_b_q ^ bus.plane_b_i[LaneW-1:0];

   // Ready passes the consumer's ready straight through when full, so a result
   // handoff and the next block's first plane can share one cycle.
   assign in_ready = !rst_i && ((state_q != ST_FULL) || bus.out_ready_i);
   assign accept   = bus.in_valid_i && in_ready;
   assign out_fire = (state_q == ST_FULL) && bus.out_ready_i;

   assign bus.in_ready_o  = in_ready;
   assign bus.out_valid_o = !rst_i && (state_q == ST_FULL);
   assign bus.parity_a_o  = acc_a_q;
   assign bus.parity_b_o  = {{(WordW-LaneW){1'b0}}, acc_b_q};
   assign bus.plane_cnt_o = cnt_q;

   // Accumulation FSM: first plane of a block loads, later planes XOR in,
   // the fifth moves to FULL until the consumer takes the result.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= 3'd0;
         acc_a_q <= '0;
         acc_b_q <= '0;
      end else if (clear_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= 3'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  acc_a_q <= bus.plane_a_i;
                  acc_b_q <= bus.plane_b_i[LaneW-1:0];
                  cnt_q   <= 3'd1;
                  state_q <= ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               if (accept) begin
                  acc_a_q <= xor_a;
                  acc_b_q <= xor_b;
                  cnt_q   <= cnt_q + 3'd1;
                  if (cnt_q == 3'(NumPlanes - 1)) begin
                     state_q <= ST_FULL;
                  end
               end
            end
            ST_FULL: begin
               if (out_fire) begin
                  if (accept) begin
                     acc_a_q <= bus.plane_a_i;
                     acc_b_q <= bus.plane_b_i[LaneW-1:0];
                     cnt_q   <= 3'd1;
                     state_q <= ST_ACCUM;
                  end else begin
                     cnt_q   <= 3'd0;
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: begin
               cnt_q   <= 3'd0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_keccak_theta_parity_acc.sv
// Bench for keccak_theta_parity_acc: directed scenarios with literal results,
// then random traffic, all checked every cycle against a plane-list model.
module tb_keccak_theta_parity_acc;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clr = 1'b0;

   keccak_theta_parity_acc_if bus();

   keccak_theta_parity_acc dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .clear_i (clr),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   int n_result = 0;

   // Model: the list of planes absorbed into the current block.
   logic [255:0] qa[$];
   logic [63:0]  qb[$];
   bit started = 1'b0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [255:0] r256();
      return {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic logic [255:0] exp_pa();
      logic [255:0] r = '0;
      foreach (qa[i]) r ^= qa[i];
      return r;
   endfunction

   function automatic logic [255:0] exp_pb();
      logic [63:0] r = '0;
      foreach (qb[i]) r ^= qb[i];
      return {192'h0, r};
   endfunction

   // Model update at each active edge from the inputs presented in that cycle.
   always @(posedge clk) begin
      bit full_now;
      bit acc;
      if (rst) begin
         started = 1'b1;
         qa.delete(); qb.delete();
      end else if (clr) begin
         qa.delete(); qb.delete();
      end else begin
         full_now = (qa.size() == 5);
         acc = bus.in_valid_i && (!full_now || bus.out_ready_i);
         if (full_now && bus.out_ready_i) begin
            n_result++;
            $display("result %0d: C[0..3]=%h C[4]=%h", n_result, exp_pa(), exp_pb()[63:0]);
            qa.delete(); qb.delete();
         end
         if (acc) begin
            qa.push_back(bus.plane_a_i);
            qb.push_back(bus.plane_b_i[63:0]);
         end
      end
   end

   // Compare process on the inactive edge.
   always @(negedge clk) begin
      if (started) begin
         bit ev;
         ev = !rst && (qa.size() == 5);
         chk("out_valid", {255'h0, bus.out_valid_o}, {255'h0, ev});
         chk("in_ready", {255'h0, bus.in_ready_o},
             {255'h0, !rst && ((qa.size() != 5) || bus.out_ready_i)});
         chk("plane_cnt", {253'h0, bus.plane_cnt_o}, 256'(qa.size()));
         chk("parity_b_hi", {64'h0, bus.parity_b_o[255:64]}, 256'h0);
         if (ev) begin
            chk("parity_a", bus.parity_a_o, exp_pa());
            chk("parity_b", bus.parity_b_o, exp_pb());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [255:0] a, input logic [63:0] b, input bit ordy);
      bus.in_valid_i  = v;
      bus.plane_a_i   = a;
      bus.plane_b_i   = {r256()[255:64], b};
      bus.out_ready_i = ordy;
      step();
   endtask

   task automatic idle_flush();
      drive(1'b0, '0, '0, 1'b1);
   endtask

   localparam logic [255:0] ONES_1F = {4{64'h1F}};
   localparam logic [255:0] A5_ALL  = {4{64'hA5A5_A5A5_A5A5_A5A5}};

   initial begin
      logic [63:0] lane;
      bus.in_valid_i = 1'b0; bus.plane_a_i = '0; bus.plane_b_i = '0; bus.out_ready_i = 1'b0;
      repeat (2) step();
      rst = 1'b0;
      #1;
      chk("rst_out_valid", {255'h0, bus.out_valid_o}, 256'h0);
      chk("rst_cnt", {253'h0, bus.plane_cnt_o}, 256'h0);
      chk("rst_in_ready", {255'h0, bus.in_ready_o}, 256'h1);
      chk("rst_parity_a", bus.parity_a_o, 256'h0);
      chk("rst_parity_b", bus.parity_b_o, 256'h0);

      // Single block of one-hot planes: every lane must read 0x1F.
      for (int y = 0; y < 5; y++) begin
         lane = 64'h1 << y;
         drive(1'b1, {4{lane}}, lane, 1'b1);
      end
      bus.in_valid_i = 1'b0;
      #1;
      chk("t1_valid", {255'h0, bus.out_valid_o}, 256'h1);
      chk("t1_pa", bus.parity_a_o, ONES_1F);
      chk("t1_pb", bus.parity_b_o, {192'h0, 64'h1F});
      chk("t1_cnt", {253'h0, bus.plane_cnt_o}, 256'd5);
      step();
      chk("t1_valid_fall", {255'h0, bus.out_valid_o}, 256'h0);
      chk("t1_cnt_zero", {253'h0, bus.plane_cnt_o}, 256'h0);

      // Two back-to-back blocks: second result must not include the first.
      for (int i = 0; i < 10; i++) begin
         lane = 64'h1 << (i % 5);
         drive(1'b1, {4{lane}}, lane, 1'b1);
         if (i % 5 == 4) begin
            chk("t2_pa", bus.parity_a_o, ONES_1F);
            chk("t2_valid", {255'h0, bus.out_valid_o}, 256'h1);
         end
      end
      idle_flush();

      // Backpressure while full.
      for (int y = 0; y < 5; y++) begin
         lane = 64'h1 << y;
         drive(1'b1, {4{lane}}, lane, 1'b1);
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, r256(), {$urandom(), $urandom()}, 1'b0);
         chk("bp_in_ready", {255'h0, bus.in_ready_o}, 256'h0);
         chk("bp_cnt", {253'h0, bus.plane_cnt_o}, 256'd5);
         chk("bp_pa_stable", bus.parity_a_o, ONES_1F);
      end
      drive(1'b1, r256(), {$urandom(), $urandom()}, 1'b1);
      chk("bp_release_cnt", {253'h0, bus.plane_cnt_o}, 256'd1);
      chk("bp_release_valid", {255'h0, bus.out_valid_o}, 256'h0);
      clr = 1'b1; idle_flush(); clr = 1'b0;

      // Continuous streaming: results after the 5th, 10th and 15th accept.
      for (int i = 0; i < 15; i++) begin
         drive(1'b1, r256(), {$urandom(), $urandom()}, 1'b1);
         chk("stream_valid", {255'h0, bus.out_valid_o}, {255'h0, (i % 5) == 4});
      end
      idle_flush();

      // Abort mid-block, then an odd count of identical planes.
      for (int i = 0; i < 3; i++) drive(1'b1, '1, '1, 1'b1);
      clr = 1'b1;
      drive(1'b1, '1, '1, 1'b1);
      clr = 1'b0;
      chk("abort_cnt", {253'h0, bus.plane_cnt_o}, 256'h0);
      for (int i = 0; i < 5; i++) drive(1'b1, A5_ALL, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0);
      chk("abort_pa", bus.parity_a_o, A5_ALL);
      chk("abort_pb", bus.parity_b_o, {192'h0, 64'hA5A5_A5A5_A5A5_A5A5});
      idle_flush();

      // Reset during accumulation (count 3) and during FULL.
      for (int i = 0; i < 3; i++) drive(1'b1, r256(), {$urandom(), $urandom()}, 1'b1);
      rst = 1'b1;
      #1;
      chk("rst_acc_in_ready", {255'h0, bus.in_ready_o}, 256'h0);
      step();
      rst = 1'b0;
      #1;
      chk("rst_acc_valid", {255'h0, bus.out_valid_o}, 256'h0);
      chk("rst_acc_cnt", {253'h0, bus.plane_cnt_o}, 256'h0);
      for (int i = 0; i < 5; i++) drive(1'b1, r256(), {$urandom(), $urandom()}, 1'b0);
      rst = 1'b1;
      #1;
      chk("rst_full_in_ready", {255'h0, bus.in_ready_o}, 256'h0);
      chk("rst_full_valid", {255'h0, bus.out_valid_o}, 256'h0);
      step();
      rst = 1'b0;
      #1;
      chk("rst_full_cnt", {253'h0, bus.plane_cnt_o}, 256'h0);
      for (int y = 0; y < 5; y++) begin
         lane = 64'h1 << y;
         drive(1'b1, {4{lane}}, lane, 1'b0);
      end
      chk("post_rst_pa", bus.parity_a_o, ONES_1F);
      idle_flush();

      // Random traffic with occasional clear and reset.
      for (int i = 0; i < 3000; i++) begin
         clr = ($urandom_range(0, 39) == 0);
         rst = ($urandom_range(0, 199) == 0);
         drive($urandom_range(0, 3) != 0, r256(), {$urandom(), $urandom()},
               $urandom_range(0, 3) != 0);
      end
      rst = 1'b0; clr = 1'b0;
      repeat (3) idle_flush();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/keccak_theta_parity_acc.md
Name: keccak_theta_parity_acc

Overview:
- Upstream feeder for the Keccak plane unit's theta step.
- Accepts the five planes (y = 0..4) of a 1600-bit Keccak state, one plane per handshake.
- XOR-accumulates them into the column-parity plane C[x] = A[x,0]^A[x,1]^A[x,2]^A[x,3]^A[x,4].
- Presents C in the two-WLEN-word packing the plane unit consumes: lanes 0..3 in word A, lane 4 in word B[63:0].

Parameters:
- NumPlanes, 5, planes accumulated per parity result. Fixed for Keccak-f[1600].
- LaneW, 64, bits per lane.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset, synchronous, active-high
- clear_i  input  1  synchronous abort; drops any partial accumulation
- in_valid_i  input  1  input plane valid
- in_ready_o  output  1  block can accept a plane
- plane_a_i  input  PQLEN*8 (256)  lanes x=0..3; lane x at [64x+:64]
- plane_b_i  input  PQLEN*8 (256)  lane x=4 at [63:0]; bits [255:64] ignored
- out_valid_o  output  1  parity plane valid
- out_ready_o... no: out_ready_i  input  1  consumer accepts parity plane
- parity_a_o  output  PQLEN*8 (256)  C[0..3], same packing as plane_a_i
- parity_b_o  output  PQLEN*8 (256)  C[4] at [63:0]; [255:64] driven 0
- plane_cnt_o  output  3  number of planes absorbed into the current accumulation (0..5)

Behaviour:
- Reset (rst_i high at a clock edge) sets the state to IDLE, the accumulator to 0 and the count to 0.
- While rst_i is high, in_ready_o = 0 and out_valid_o = 0 combinationally.
- After reset: out_valid_o = 0, parity_a_o = parity_b_o = 0, plane_cnt_o = 0, in_ready_o = 1.
- States:
  - IDLE: count = 0.
  - ACCUM: 1 <= count <= 4.
  - FULL: count = 5, out_valid_o = 1.
- A plane is accepted on in_valid_i & in_ready_o at the clock edge.
- IDLE accept: accumulator loads the plane (no XOR with stale data). Count becomes 1; state goes to ACCUM.
- ACCUM accept: accumulator ^= plane and count increments.
  - If count reaches 5, state goes to FULL and out_valid_o rises in the cycle after the 5th accept. Latency is 1 cycle.
- in_ready_o = (state != FULL) | out_ready_i. This is combinational pass-through, so there is no bubble between blocks.
- FULL:
  - Outputs hold stable while out_valid_o & !out_ready_i.
  - in_valid_i is ignored unless out_ready_i is high.
  - out handshake with no input accept: next state IDLE, count 0. Accumulator is not cleared, but outputs are don't-care after out_valid_o falls.
  - out handshake and input accept in the same cycle: the new plane loads as the first plane of the next block. Count becomes 1; state goes to ACCUM.
- parity outputs are driven directly from the accumulator register (no combinational path from plane inputs).
- parity_b_o[255:64] = 0 at all times.
- clear_i:
  - Priority below rst_i and above every handshake.
  - State goes to IDLE, count 0, out_valid_o falls the next cycle.
  - in_ready_o stays per the formula in the clear cycle, but any plane presented in that cycle is discarded.
  - A pending FULL result is discarded.
- in_valid_i low in ACCUM: state, count and accumulator hold, with no timeout.
- Each accumulator bit is a pure XOR of the absorbed planes' corresponding bits. There are no carries and no cross-lane mixing.

Test Plan:
- Reset, then 5 planes with plane_a_i = {4{64'h1<<y}}, plane_b_i[63:0] = 64'h1<<y for y = 0..4, out_ready_i = 1 -> one cycle after the 5th accept: out_valid_o = 1, every lane of parity_a_o = 64'h1F, parity_b_o = {192'h0, 64'h1F}, plane_cnt_o = 5; next cycle out_valid_o = 0, plane_cnt_o = 0.
- Same planes repeated twice (10 accepts) -> each result is 64'h1F per lane. This checks that the first-plane load does not XOR in the previous block.
- Backpressure: hold out_ready_i = 0 for 4 cycles in FULL while in_valid_i = 1 -> in_ready_o = 0, outputs stable, no plane absorbed; release -> handshake, and the new plane is accepted in the same cycle with plane_cnt_o = 1 next cycle.
- Back-to-back streaming: in_valid_i = out_ready_i = 1 constantly for 15 planes -> 3 results, on cycles 6, 11 and 16 after the first accept, with zero input stall cycles.
- Abort: 3 planes of all-ones, then clear_i together with a 4th plane -> plane_cnt_o = 0; 5 fresh planes of 64'hA5A5... (odd count) -> result lanes = 64'hA5A5_A5A5_A5A5_A5A5.
- rst_i asserted in ACCUM with count 3, and again in FULL -> the next cycle has out_valid_o = 0 and plane_cnt_o = 0, and in_ready_o = 0 while rst_i is high; a subsequent 5-plane sequence is correct.
